muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the MIPS datapath; executes MULT, MULTU, DIV and DIVU in the EX stage.
- Results go to architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write.
- The ALU control decoder selects the operation; the pipeline stalls while busy is high.
- Successor to the single-cycle mult/div encodings in the ALU path: multi-cycle, signed and unsigned, with divide-by-zero reporting.

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up, and the architectural HI/LO registers (MTHI/MTLO writable).
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W = WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2*W-1:0] acc, acc_step, acc_fix;
  logic [W-1:0]   bb;
  logic [CNT_W-1:0] cnt;
  logic           is_div, sa, sb, bzero;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_abs, b_abs, q, r;
  logic [W:0]     mul_sum, div_sh, div_diff;

  // Signed ops run on magnitudes; the signs are reapplied in FIX.
  assign a_neg = ~op[0] & a[W-1];
  assign b_neg = ~op[0] & b[W-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, bb};
  assign div_sh   = {acc[2*W-1:W], acc[W-1]};
  assign div_diff = div_sh - {1'b0, bb};

  always_comb begin
    acc_step = acc;
    if (is_div)
      acc_step = div_diff[W] ? {div_sh[W-1:0], acc[W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_step = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
  end

  assign q = acc[W-1:0];
  assign r = acc[2*W-1:W];

  // Remainder follows the dividend sign; a zero divisor leaves the raw
  // dividend in the remainder half and forces the quotient to all ones.
  always_comb begin
    acc_fix = acc;
    if (is_div) begin
      acc_fix[W-1:0]   = bzero ? '1 : ((sa ^ sb) ? -q : q);
      acc_fix[2*W-1:W] = sa ? -r : r;
    end else if (sa ^ sb) begin
      acc_fix = -acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      bb       <= '0;
      is_div   <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      bzero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            is_div <= op[1];
            sa     <= a_neg;
            sb     <= b_neg;
            bzero  <= (b == '0);
            bb     <= op[1] ? b_abs : a_abs;
            acc    <= {{W{1'b0}}, (op[1] ? a_abs : b_abs)};
            cnt    <= CNT_W'(WIDTH);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: acc <= acc_fix;
        DONE: begin
          hi       <= acc[2*W-1:W];
          lo       <= acc[W-1:0];
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= is_div & bzero;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 32-bit DUT
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));

  // 8-bit DUT
  logic       start8, hi_we8, lo_we8;
  logic [1:0] op8;
  logic [7:0] a8, b8, wdata8;
  logic       busy8, done8, div_zero8;
  logic [7:0] hi8, lo8;

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8));

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        dz;
    int          t;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  logic [63:0] last_hi, last_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic at width w.
  function automatic void model(input int w, input logic [1:0] o,
                                input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] h, output logic [63:0] l,
                                output logic dz);
    logic [63:0] mask, pu;
    longint sx, sy, p, qq, rr;
    mask = (64'd1 << w) - 64'd1;
    sx = x[w-1] ? longint'(x) - longint'(64'd1 << w) : longint'(x);
    sy = y[w-1] ? longint'(y) - longint'(64'd1 << w) : longint'(y);
    dz = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin p = sx * sy; pu = p; h = (pu >> w) & mask; l = pu & mask; end
      2'd1: begin pu = x * y; h = (pu >> w) & mask; l = pu & mask; end
      default: begin
        if (y == 64'd0) begin
          h = x; l = mask; dz = 1'b1;
        end else if (o == 2'd2) begin
          qq = sx / sy; rr = sx % sy;
          pu = qq; l = pu & mask;
          pu = rr; h = pu & mask;
        end else begin
          l = x / y; h = x % y;
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL done32_spurious: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("hi32", {32'b0, hi}, e.hi);
        chk("lo32", {32'b0, lo}, e.lo);
        chk("dz32", {63'b0, div_zero}, {63'b0, e.dz});
        chk("lat32", 64'(cyc), 64'(e.t));
      end
    end
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_spurious: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("hi8", {56'b0, hi8}, e.hi);
        chk("lo8", {56'b0, lo8}, e.lo);
        chk("dz8", {63'b0, div_zero8}, {63'b0, e.dz});
        chk("lat8", 64'(cyc), 64'(e.t));
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push);
    exp_t e;
    logic [63:0] h, l;
    logic dz;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      model(32, o, {32'b0, x}, {32'b0, y}, h, l, dz);
      e.hi = h; e.lo = l; e.dz = dz; e.t = cyc + 1 + 32 + 2;
      q32.push_back(e);
      last_hi = h; last_lo = l;
    end
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [63:0] h, l;
    logic dz;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    model(8, o, {56'b0, x}, {56'b0, y}, h, l, dz);
    e.hi = h; e.lo = l; e.dz = dz; e.t = cyc + 1 + 8 + 2;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait32();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL timeout32: busy stuck high after %0d cycles", n);
    end
  endtask

  task automatic wait8();
    int n = 0;
    while (busy8 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL timeout8: busy stuck high after %0d cycles", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [7:0]  x8, y8;
    int          sel;

    rst = 1'b1;
    start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; wdata = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; hi_we8 = 0; lo_we8 = 0; wdata8 = 0;
    last_hi = 0; last_lo = 0;
    #23;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dz", {63'b0, div_zero}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back to back.
    issue32(2'd0, 32'hFFFFFFFD, 32'd7, 1); wait32();
    issue32(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); wait32();
    issue32(2'd2, 32'hFFFFFFF9, 32'd2, 1); wait32();
    issue32(2'd3, 32'd100, 32'd0, 1); wait32();
    issue32(2'd3, 32'd100, 32'd7, 1); wait32();
    issue32(2'd2, 32'h80000000, 32'hFFFFFFFF, 1); wait32();

    // Start and MTHI while busy must both be ignored.
    issue32(2'd0, 32'd12345, 32'd678, 1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait32();

    // MTHI / MTLO in IDLE.
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {32'b0, hi}, 64'h1234);
    chk("mthi_lo_kept", {32'b0, lo}, last_lo);
    lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {32'b0, lo}, 64'hABCD);

    // MTHI together with start: the write is dropped.
    hi_we = 1'b1; wdata = 32'h5555;
    issue32(2'd1, 32'd3, 32'd4, 1);
    hi_we = 1'b0;
    chk("mthi_vs_start", {32'b0, hi}, 64'h1234);
    wait32();

    // Randomised back-to-back ops with corner operands mixed in.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      o = 2'($urandom_range(0, 3));
      x = $urandom; y = $urandom;
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      else if (sel == 2) begin x = $urandom_range(0, 20); y = $urandom_range(0, 20); end
      else if (sel == 3) y = y >> 20;
      issue32(o, x, y, 1);
      wait32();
    end

    // HI/LO hold while idle.
    repeat (4) @(negedge clk);
    chk("hold_hi", {32'b0, hi}, last_hi);
    chk("hold_lo", {32'b0, lo}, last_lo);

    // Asynchronous reset mid-calculation discards the op.
    issue32(2'd0, 32'd77, 32'd88, 0);
    repeat (6) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_hi", {32'b0, hi}, 64'd0);
    chk("arst_lo", {32'b0, lo}, 64'd0);
    chk("arst_dz", {63'b0, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue32(2'd0, 32'd5, 32'd6, 1); wait32();

    // WIDTH=8 instance.
    @(negedge clk);
    issue8(2'd2, 8'h80, 8'd3); wait8();
    issue8(2'd2, 8'h80, 8'hFF); wait8();
    issue8(2'd3, 8'd55, 8'd0); wait8();
    issue8(2'd0, 8'h80, 8'h80); wait8();
    for (int i = 0; i < 20; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) y8 = 8'd0;
      issue8(2'($urandom_range(0, 3)), x8, y8);
      wait8();
    end

    repeat (4) @(negedge clk);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
